// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: board-level run/stop/step/halt sequencer for the CPU clock-enable,
// with a selectable divide rate, a retired-enable counter and a free-running LED-scan tick.
module cpu_run_ctrl #(
    parameter int unsigned CPU_DIV = 10000000,
    parameter int unsigned LED_DIV = 100000
) (
    input  logic        clk_board,
    input  logic        rst,
    input  logic        btn_run,
    input  logic        btn_pause,
    input  logic        btn_step,
    input  logic        halt,
    input  logic [1:0]  speed_sel,
    output logic        cpu_ce,
    output logic        led_tick,
    output logic [1:0]  state,
    output logic        running,
    output logic [31:0] cycle_count
);

    typedef enum logic [1:0] {
        StStop = 2'd0,
        StRun  = 2'd1,
        StStep = 2'd2,
        StHalt = 2'd3
    } run_state_e;

    // Divide lengths per speed setting; a length that shifts down to zero runs at full rate.
    localparam int unsigned DivLen0 = CPU_DIV;
    localparam int unsigned DivLen1 = ((CPU_DIV >> 2) == 0) ? 1 : (CPU_DIV >> 2);
    localparam int unsigned DivLen2 = ((CPU_DIV >> 4) == 0) ? 1 : (CPU_DIV >> 4);
    localparam logic [31:0] DivLast0 = 32'(DivLen0 - 1);
    localparam logic [31:0] DivLast1 = 32'(DivLen1 - 1);
    localparam logic [31:0] DivLast2 = 32'(DivLen2 - 1);

    localparam int unsigned LedW = $clog2(LED_DIV);
    localparam logic [LedW-1:0] LedLast = LedW'(LED_DIV - 1);

    run_state_e      state_q, state_d;
    logic            btn_run_q, btn_pause_q, btn_step_q;
    logic            run_press, pause_press, step_press;
    logic [31:0]     div_cnt_q, div_cnt_d;
    logic [31:0]     div_last;
    logic            cpu_ce_q, cpu_ce_d;
    logic [31:0]     cycle_count_q, cycle_count_d;
    logic [LedW-1:0] led_cnt_q, led_cnt_d;
    logic            led_tick_q, led_tick_d;

    assign run_press   = btn_run & ~btn_run_q;
    assign pause_press = btn_pause & ~btn_pause_q;
    assign step_press  = btn_step & ~btn_step_q;

    // Button history is loaded even during reset so a button held through reset is not a press.
    always_ff @(posedge clk_board) begin
        btn_run_q   <= btn_run;
        btn_pause_q <= btn_pause;
        btn_step_q  <= btn_step;
    end

    // Select the divider terminal count for the current speed setting.
    always_comb begin
        div_last = DivLast0;
        case (speed_sel)
            2'b00:   div_last = DivLast0;
            2'b01:   div_last = DivLast1;
            2'b10:   div_last = DivLast2;
            default: div_last = '0;
        endcase
    end

    // Run-control next state from button presses and the CPU halt request.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StStop: begin
                if (run_press) begin
                    state_d = StRun;
                end else if (step_press) begin
                    state_d = halt ? StHalt : StStep;
                end
            end
            StRun: begin
                if (halt) begin
                    state_d = StHalt;
                end else if (pause_press) begin
                    state_d = StStop;
                end
            end
            StStep: state_d = halt ? StHalt : StStop;
            StHalt: begin
                if (run_press && !halt) begin
                    state_d = StRun;
                end
            end
        endcase
    end

    // Clock-enable divider: counts only while staying in RUN; STEP entry issues one enable.
    always_comb begin
        div_cnt_d     = '0;
        cpu_ce_d      = 1'b0;
        cycle_count_d = cycle_count_q;
        if (state_q == StRun && state_d == StRun) begin
            // >= so a speed change that drops the limit below the count fires at once
            if (div_cnt_q >= div_last) begin
                cpu_ce_d      = 1'b1;
                cycle_count_d = cycle_count_q + 32'd1;
            end else begin
                div_cnt_d = div_cnt_q + 32'd1;
            end
        end else if (state_d == StStep) begin
            cpu_ce_d      = 1'b1;
            cycle_count_d = cycle_count_q + 32'd1;
        end
    end

    // Free-running LED scan divider.
    always_comb begin
        led_cnt_d  = led_cnt_q + LedW'(1);
        led_tick_d = 1'b0;
        if (led_cnt_q == LedLast) begin
            led_cnt_d  = '0;
            led_tick_d = 1'b1;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk_board) begin
        if (rst) begin
            state_q       <= StStop;
            div_cnt_q     <= '0;
            cpu_ce_q      <= 1'b0;
            cycle_count_q <= '0;
            led_cnt_q     <= '0;
            led_tick_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            cpu_ce_q      <= cpu_ce_d;
            cycle_count_q <= cycle_count_d;
            led_cnt_q     <= led_cnt_d;
            led_tick_q    <= led_tick_d;
        end
    end

    assign cpu_ce      = cpu_ce_q;
    assign led_tick    = led_tick_q;
    assign state       = state_q;
    assign running     = (state_q == StRun);
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios followed by randomized buttons/halt/speed/reset
// compared every cycle against a behavioural model.
module tb_cpu_run_ctrl;

    localparam int unsigned CpuDiv = 8;
    localparam int unsigned LedDiv = 5;

    logic        clk_board = 1'b0;
    logic        rst = 1'b1;
    logic        btn_run = 1'b0;
    logic        btn_pause = 1'b0;
    logic        btn_step = 1'b0;
    logic        halt = 1'b0;
    logic [1:0]  speed_sel = 2'b00;
    logic        cpu_ce;
    logic        led_tick;
    logic [1:0]  state;
    logic        running;
    logic [31:0] cycle_count;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_cnt = '0;

    cpu_run_ctrl #(
        .CPU_DIV(CpuDiv),
        .LED_DIV(LedDiv)
    ) dut (
        .clk_board  (clk_board),
        .rst        (rst),
        .btn_run    (btn_run),
        .btn_pause  (btn_pause),
        .btn_step   (btn_step),
        .halt       (halt),
        .speed_sel  (speed_sel),
        .cpu_ce     (cpu_ce),
        .led_tick   (led_tick),
        .state      (state),
        .running    (running),
        .cycle_count(cycle_count)
    );

    always #5 clk_board = ~clk_board;

    initial begin
        #5ms;
        $display("FAIL watchdog: time limit reached before the end of the run");
        $fatal(1);
    end

    // Advance one clock; outputs are read and inputs changed 1 ns after the edge.
    task automatic cyc();
        @(posedge clk_board);
        #1;
    endtask

    function automatic int unsigned div_len(input logic [1:0] sel);
        int unsigned l;
        case (sel)
            2'b00:   l = CpuDiv;
            2'b01:   l = CpuDiv / 4;
            2'b10:   l = CpuDiv / 16;
            default: l = 1;
        endcase
        if (l == 0) l = 1;
        return l;
    endfunction

    task automatic test_reset();
        logic exp_tick;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        exp_cnt = '0;
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", state);
        end
        checks++;
        if (cpu_ce !== 1'b0) begin
            errors++;
            $display("FAIL reset_cpu_ce: got %b expected 0", cpu_ce);
        end
        checks++;
        if (cycle_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_cycle_count: got %0d expected 0", cycle_count);
        end
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL reset_running: got %b expected 0", running);
        end
        checks++;
        if (led_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_led_tick: got %b expected 0", led_tick);
        end
        for (int e = 1; e <= 15; e++) begin
            cyc();
            exp_tick = ((e % LedDiv) == 0);
            checks++;
            if (led_tick !== exp_tick) begin
                errors++;
                $display("FAIL led_phase edge %0d: got %b expected %b", e, led_tick, exp_tick);
            end
        end
    endtask

    task automatic test_run_pause();
        logic exp_ce;
        speed_sel = 2'b00;
        btn_run = 1'b1;
        cyc();
        btn_run = 1'b0;
        checks++;
        if (state !== 2'd1 || running !== 1'b1) begin
            errors++;
            $display("FAIL run_entry: got state %0d running %b expected 1 1", state, running);
        end
        for (int e = 1; e <= 24; e++) begin
            cyc();
            exp_ce = ((e % CpuDiv) == 0);
            if (exp_ce) exp_cnt = exp_cnt + 32'd1;
            checks++;
            if (cpu_ce !== exp_ce) begin
                errors++;
                $display("FAIL run_ce edge %0d: got %b expected %b", e, cpu_ce, exp_ce);
            end
        end
        checks++;
        if (cycle_count !== exp_cnt) begin
            errors++;
            $display("FAIL run_count: got %0d expected %0d", cycle_count, exp_cnt);
        end
        btn_pause = 1'b1;
        cyc();
        btn_pause = 1'b0;
        checks++;
        if (state !== 2'd0 || running !== 1'b0) begin
            errors++;
            $display("FAIL pause_state: got state %0d running %b expected 0 0", state, running);
        end
        for (int e = 0; e < 10; e++) begin
            cyc();
            checks++;
            if (cpu_ce !== 1'b0) begin
                errors++;
                $display("FAIL stopped_ce cycle %0d: got %b expected 0", e, cpu_ce);
            end
        end
        checks++;
        if (cycle_count !== exp_cnt) begin
            errors++;
            $display("FAIL stopped_count: got %0d expected %0d", cycle_count, exp_cnt);
        end
    endtask

    task automatic test_step();
        for (int n = 0; n < 3; n++) begin
            btn_step = 1'b1;
            cyc();
            btn_step = 1'b0;
            exp_cnt = exp_cnt + 32'd1;
            checks++;
            if (state !== 2'd2 || cpu_ce !== 1'b1) begin
                errors++;
                $display("FAIL step_pulse %0d: got state %0d ce %b expected 2 1", n, state, cpu_ce);
            end
            cyc();
            checks++;
            if (state !== 2'd0 || cpu_ce !== 1'b0) begin
                errors++;
                $display("FAIL step_return %0d: got state %0d ce %b expected 0 0", n, state, cpu_ce);
            end
            cyc();
            cyc();
        end
        checks++;
        if (cycle_count !== exp_cnt) begin
            errors++;
            $display("FAIL step_count: got %0d expected %0d", cycle_count, exp_cnt);
        end
    endtask

    task automatic test_halt();
        btn_run = 1'b1;
        cyc();
        btn_run = 1'b0;
        repeat (7) cyc();
        // Halt is sampled on the edge that would otherwise issue the 8th-edge enable.
        halt = 1'b1;
        cyc();
        checks++;
        if (state !== 2'd3 || cpu_ce !== 1'b0) begin
            errors++;
            $display("FAIL halt_entry: got state %0d ce %b expected 3 0", state, cpu_ce);
        end
        btn_run = 1'b1;
        cyc();
        btn_run = 1'b0;
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL halt_run_while_halt: got %0d expected 3", state);
        end
        cyc();
        btn_step = 1'b1;
        cyc();
        btn_step = 1'b0;
        checks++;
        if (state !== 2'd3 || cpu_ce !== 1'b0) begin
            errors++;
            $display("FAIL halt_step: got state %0d ce %b expected 3 0", state, cpu_ce);
        end
        btn_pause = 1'b1;
        cyc();
        btn_pause = 1'b0;
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL halt_pause: got %0d expected 3", state);
        end
        halt = 1'b0;
        cyc();
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL halt_no_press: got %0d expected 3", state);
        end
        btn_run = 1'b1;
        cyc();
        btn_run = 1'b0;
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL halt_resume: got %0d expected 1", state);
        end
        btn_pause = 1'b1;
        cyc();
        btn_pause = 1'b0;
        cyc();
        checks++;
        if (state !== 2'd0 || cycle_count !== exp_cnt) begin
            errors++;
            $display("FAIL halt_exit: got state %0d count %0d expected 0 %0d",
                     state, cycle_count, exp_cnt);
        end
    endtask

    task automatic test_simultaneous();
        btn_run = 1'b1;
        btn_step = 1'b1;
        cyc();
        btn_run = 1'b0;
        btn_step = 1'b0;
        checks++;
        if (state !== 2'd1 || cpu_ce !== 1'b0) begin
            errors++;
            $display("FAIL run_step_together: got state %0d ce %b expected 1 0", state, cpu_ce);
        end
        halt = 1'b1;
        btn_pause = 1'b1;
        cyc();
        halt = 1'b0;
        btn_pause = 1'b0;
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL halt_pause_together: got %0d expected 3", state);
        end
        cyc();
        btn_run = 1'b1;
        cyc();
        btn_run = 1'b0;
        btn_pause = 1'b1;
        cyc();
        btn_pause = 1'b0;
        cyc();
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL simultaneous_exit: got %0d expected 0", state);
        end
    endtask

    task automatic test_speed_change();
        logic exp_ce;
        speed_sel = 2'b00;
        btn_run = 1'b1;
        cyc();
        btn_run = 1'b0;
        repeat (5) cyc();
        speed_sel = 2'b01;
        for (int e = 6; e <= 11; e++) begin
            cyc();
            exp_ce = ((e % 2) == 0);
            if (exp_ce) exp_cnt = exp_cnt + 32'd1;
            checks++;
            if (cpu_ce !== exp_ce) begin
                errors++;
                $display("FAIL speed_change edge %0d: got %b expected %b", e, cpu_ce, exp_ce);
            end
        end
        btn_pause = 1'b1;
        cyc();
        btn_pause = 1'b0;
        speed_sel = 2'b00;
        checks++;
        if (cycle_count !== exp_cnt) begin
            errors++;
            $display("FAIL speed_count: got %0d expected %0d", cycle_count, exp_cnt);
        end
    endtask

    task automatic test_reset_hold();
        btn_run = 1'b1;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        exp_cnt = '0;
        checks++;
        if (state !== 2'd0 || cycle_count !== 32'd0) begin
            errors++;
            $display("FAIL hold_reset: got state %0d count %0d expected 0 0", state, cycle_count);
        end
        for (int e = 0; e < 3; e++) begin
            cyc();
            checks++;
            if (state !== 2'd0 || cpu_ce !== 1'b0) begin
                errors++;
                $display("FAIL hold_no_cmd %0d: got state %0d ce %b expected 0 0", e, state, cpu_ce);
            end
        end
        btn_run = 1'b0;
        cyc();
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL hold_release: got %0d expected 0", state);
        end
    endtask

    task automatic test_reset_mid_run();
        logic exp_tick;
        btn_run = 1'b1;
        cyc();
        btn_run = 1'b0;
        repeat (20) cyc();
        exp_cnt = exp_cnt + 32'd2;
        checks++;
        if (state !== 2'd1 || cycle_count !== exp_cnt) begin
            errors++;
            $display("FAIL pre_reset_run: got state %0d count %0d expected 1 %0d",
                     state, cycle_count, exp_cnt);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_cnt = '0;
        checks++;
        if (state !== 2'd0 || cycle_count !== 32'd0 || cpu_ce !== 1'b0 ||
            led_tick !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_reset: got state %0d count %0d ce %b tick %b run %b expected 0s",
                     state, cycle_count, cpu_ce, led_tick, running);
        end
        for (int e = 1; e <= 10; e++) begin
            cyc();
            exp_tick = ((e % LedDiv) == 0);
            checks++;
            if (led_tick !== exp_tick) begin
                errors++;
                $display("FAIL led_restart edge %0d: got %b expected %b", e, led_tick, exp_tick);
            end
        end
    endtask

    // Random stimulus against a model stated in terms of commands, elapsed edges and LED age.
    task automatic test_random();
        int          m_state;
        int          nxt;
        logic        m_ce;
        logic        m_tick;
        logic [31:0] m_cnt;
        int unsigned m_elapsed;
        int unsigned m_age;
        logic        pr, pp, ps;
        logic        run_p, pause_p, step_p;
        pr = 1'b0;
        pp = 1'b0;
        ps = 1'b0;
        m_state = 0;
        m_ce = 1'b0;
        m_tick = 1'b0;
        m_cnt = '0;
        m_elapsed = 0;
        m_age = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) btn_run = ~btn_run;
            if ($urandom_range(3) == 0) btn_pause = ~btn_pause;
            if ($urandom_range(3) == 0) btn_step = ~btn_step;
            if ($urandom_range(15) == 0) halt = ~halt;
            if ($urandom_range(31) == 0) speed_sel = 2'($urandom_range(3));
            rst = (i == 0) || ($urandom_range(199) == 0);

            run_p = btn_run && !pr;
            pause_p = btn_pause && !pp;
            step_p = btn_step && !ps;
            if (rst) begin
                m_state = 0;
                m_ce = 1'b0;
                m_tick = 1'b0;
                m_cnt = '0;
                m_elapsed = 0;
                m_age = 0;
            end else begin
                nxt = m_state;
                if (m_state == 0) begin
                    if (run_p) nxt = 1;
                    else if (step_p) nxt = halt ? 3 : 2;
                end else if (m_state == 1) begin
                    if (halt) nxt = 3;
                    else if (pause_p) nxt = 0;
                end else if (m_state == 2) begin
                    nxt = halt ? 3 : 0;
                end else begin
                    if (run_p && !halt) nxt = 1;
                end
                m_ce = 1'b0;
                if (m_state == 1 && nxt == 1) begin
                    // This edge completes a period once L edges have elapsed.
                    if (m_elapsed + 1 >= div_len(speed_sel)) begin
                        m_elapsed = 0;
                        m_ce = 1'b1;
                        m_cnt = m_cnt + 32'd1;
                    end else begin
                        m_elapsed = m_elapsed + 1;
                    end
                end else begin
                    m_elapsed = 0;
                    if (nxt == 2) begin
                        m_ce = 1'b1;
                        m_cnt = m_cnt + 32'd1;
                    end
                end
                m_state = nxt;
                m_age = m_age + 1;
                m_tick = ((m_age % LedDiv) == 0);
            end
            pr = btn_run;
            pp = btn_pause;
            ps = btn_step;

            cyc();
            checks++;
            if (state !== 2'(m_state)) begin
                errors++;
                $display("FAIL rand_state cycle %0d: got %0d expected %0d", i, state, m_state);
            end
            checks++;
            if (cpu_ce !== m_ce) begin
                errors++;
                $display("FAIL rand_cpu_ce cycle %0d: got %b expected %b", i, cpu_ce, m_ce);
            end
            checks++;
            if (cycle_count !== m_cnt) begin
                errors++;
                $display("FAIL rand_count cycle %0d: got %0d expected %0d", i, cycle_count, m_cnt);
            end
            checks++;
            if (led_tick !== m_tick) begin
                errors++;
                $display("FAIL rand_led_tick cycle %0d: got %b expected %b", i, led_tick, m_tick);
            end
            checks++;
            if (running !== (m_state == 1)) begin
                errors++;
                $display("FAIL rand_running cycle %0d: got %b expected %b",
                         i, running, (m_state == 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_run_pause();
        test_step();
        test_halt();
        test_simultaneous();
        test_speed_change();
        test_reset_hold();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
